// File: rtl/rmw_counter_pkg.sv
// Shared definitions for the fetch-and-operate counter table: op codes,
// controller states and the address-width helper.
package rmw_counter_pkg;

  typedef enum logic [1:0] {
    OP_READ = 2'b00,
    OP_INC  = 2'b01,
    OP_ADD  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 32'sd0;
    v      = value - 32'sd1;
    while (v > 32'sd0) begin
      result = result + 32'sd1;
      v      = v >>> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rmw_counter_table_if.sv
// Request/response bundle of the counter table; the client drives requests
// and the table drives ready, results and the busy flag.
interface rmw_counter_table_if #(
  parameter int ADDR_W = 3,
  parameter int WIDTH  = 32
);

  logic              io_in_valid;
  logic              io_in_ready;
  logic [1:0]        io_in_op;
  logic [ADDR_W-1:0] io_in_addr;
  logic [WIDTH-1:0]  io_in_data;
  logic              io_clr_all;
  logic              io_out_valid;
  logic [WIDTH-1:0]  io_out_data;
  logic              io_out_ovf;
  logic              io_busy;

  modport master (
    output io_in_valid, io_in_op, io_in_addr, io_in_data, io_clr_all,
    input  io_in_ready, io_out_valid, io_out_data, io_out_ovf, io_busy
  );

  modport slave (
    input  io_in_valid, io_in_op, io_in_addr, io_in_data, io_clr_all,
    output io_in_ready, io_out_valid, io_out_data, io_out_ovf, io_busy
  );

endinterface

// File: rtl/rmw_table_ram.sv
// Counter storage: one registered read port and one write port; the array
// itself is never reset, it is cleared by the controller's sweep.
module rmw_table_ram #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rd_data_r;

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read port returns the pre-write contents on a same-address collision
  always_ff @(posedge clk) begin
    rd_data_r <= mem_r[rd_addr];
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/rmw_counter_table.sv
// Pipelined read/modify/write counter table with forwarding between
// back-to-back ops and a zeroing sweep after reset or on request.
module rmw_counter_table
  import rmw_counter_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = clog2(DEPTH),
  parameter int SATURATE = 0
) (
  input logic                clk,
  input logic                reset,
  rmw_counter_table_if.slave bus
);

  state_e            state_r;
  state_e            state_nxt_s;
  logic [ADDR_W-1:0] ptr_r;
  logic              accept_s;

  logic              s1_valid_r;
  op_e               s1_op_r;
  logic [ADDR_W-1:0] s1_addr_r;
  logic [WIDTH-1:0]  s1_data_r;
  logic              s1_fwd_r;
  logic [WIDTH-1:0]  s1_fwd_val_r;
  logic [WIDTH-1:0]  s1_old_s;
  logic [WIDTH-1:0]  addend_s;
  logic [WIDTH:0]    sum_s;
  logic [WIDTH-1:0]  s1_new_s;
  logic              s1_ovf_s;
  logic              s1_we_s;

  logic [WIDTH-1:0]  ram_rd_s;
  logic              ram_we_s;
  logic [ADDR_W-1:0] ram_wr_addr_s;
  logic [WIDTH-1:0]  ram_wr_data_s;

  logic              out_valid_r;
  logic [WIDTH-1:0]  out_data_r;
  logic              out_ovf_r;

  // A clear request wins over a simultaneous operation request
  assign accept_s = (state_r == RUN) && bus.io_in_valid && !bus.io_clr_all;

  // Controller next state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      SWEEP: begin
        if (ptr_r == ADDR_W'(DEPTH - 1)) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = SWEEP;
        end
      end
      RUN: begin
        if (bus.io_clr_all) begin
          state_nxt_s = SWEEP;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: state_nxt_s = SWEEP;
    endcase
  end

  // Controller state and sweep pointer
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= SWEEP;
      ptr_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == SWEEP) begin
        ptr_r <= ptr_r + ADDR_W'(1);
      end else if (bus.io_clr_all) begin
        ptr_r <= '0;
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

  // The operand comes from S1's result when S1 is writing the same entry
  assign s1_old_s = s1_fwd_r ? s1_fwd_val_r : ram_rd_s;

  // Addend selection
  always_comb begin
    addend_s = '0;
    case (s1_op_r)
      OP_INC:  addend_s = WIDTH'(1);
      OP_ADD:  addend_s = s1_data_r;
      default: addend_s = '0;
    endcase
  end

  assign sum_s = {1'b0, s1_old_s} + {1'b0, addend_s};

  // Result, overflow flag and write enable per op
  always_comb begin
    s1_new_s = s1_old_s;
    s1_ovf_s = 1'b0;
    s1_we_s  = 1'b0;
    case (s1_op_r)
      OP_READ: begin
        s1_new_s = s1_old_s;
      end
      OP_INC, OP_ADD: begin
        s1_we_s  = 1'b1;
        s1_ovf_s = sum_s[WIDTH];
        if ((SATURATE != 32'sd0) && sum_s[WIDTH]) begin
          s1_new_s = '1;
        end else begin
          s1_new_s = sum_s[WIDTH-1:0];
        end
      end
      OP_CLR: begin
        s1_we_s  = 1'b1;
        s1_new_s = '0;
      end
      default: begin
        s1_new_s = s1_old_s;
      end
    endcase
  end

  // The sweep owns the write port whenever it is running
  always_comb begin
    ram_we_s      = 1'b0;
    ram_wr_addr_s = s1_addr_r;
    ram_wr_data_s = s1_new_s;
    if (!reset) begin
      ram_we_s = 1'b0;
    end else if (state_r == SWEEP) begin
      ram_we_s      = 1'b1;
      ram_wr_addr_s = ptr_r;
      ram_wr_data_s = '0;
    end else begin
      ram_we_s = s1_valid_r && s1_we_s;
    end
  end

  rmw_table_ram #(
    .DEPTH  (DEPTH),
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rd_addr (bus.io_in_addr),
    .rd_data (ram_rd_s),
    .we      (ram_we_s),
    .wr_addr (ram_wr_addr_s),
    .wr_data (ram_wr_data_s)
  );

  // S1 capture of the accepted request
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_r   <= 1'b0;
      s1_op_r      <= OP_READ;
      s1_addr_r    <= '0;
      s1_data_r    <= '0;
      s1_fwd_r     <= 1'b0;
      s1_fwd_val_r <= '0;
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_op_r      <= op_e'(bus.io_in_op);
        s1_addr_r    <= bus.io_in_addr;
        s1_data_r    <= bus.io_in_data;
        s1_fwd_r     <= s1_valid_r && (s1_addr_r == bus.io_in_addr);
        s1_fwd_val_r <= s1_new_s;
      end else begin
        s1_fwd_r <= 1'b0;
      end
    end
  end

  // Result registers hold their value between pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_ovf_r   <= 1'b0;
    end else begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_data_r <= s1_old_s;
        out_ovf_r  <= s1_ovf_s;
      end else begin
        out_data_r <= out_data_r;
        out_ovf_r  <= out_ovf_r;
      end
    end
  end

  assign bus.io_in_ready  = (state_r == RUN);
  assign bus.io_busy      = (state_r == SWEEP);
  assign bus.io_out_valid = out_valid_r;
  assign bus.io_out_data  = out_data_r;
  assign bus.io_out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_rmw_counter_table.sv
// Bench for rmw_counter_table: a wrapping and a saturating 8x4 instance share
// one stimulus stream and are compared every cycle against a table model.
module tb_rmw_counter_table;
  import rmw_counter_pkg::*;

  localparam int DEPTH = 8;
  localparam int WIDTH = 4;
  localparam int MAXV  = 15;

  logic       clk = 1'b0;
  logic       reset_s;
  logic       in_valid_s;
  logic [1:0] in_op_s;
  logic [2:0] in_addr_s;
  logic [3:0] in_data_s;
  logic       clr_all_s;

  always #5 clk = ~clk;

  rmw_counter_table_if #(.ADDR_W(3), .WIDTH(WIDTH)) bus0 ();
  rmw_counter_table_if #(.ADDR_W(3), .WIDTH(WIDTH)) bus1 ();

  assign bus0.io_in_valid = in_valid_s;
  assign bus0.io_in_op    = in_op_s;
  assign bus0.io_in_addr  = in_addr_s;
  assign bus0.io_in_data  = in_data_s;
  assign bus0.io_clr_all  = clr_all_s;
  assign bus1.io_in_valid = in_valid_s;
  assign bus1.io_in_op    = in_op_s;
  assign bus1.io_in_addr  = in_addr_s;
  assign bus1.io_in_data  = in_data_s;
  assign bus1.io_clr_all  = clr_all_s;

  rmw_counter_table #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SATURATE(0)) dut_wrap (
    .clk   (clk),
    .reset (reset_s),
    .bus   (bus0)
  );

  rmw_counter_table #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SATURATE(1)) dut_sat (
    .clk   (clk),
    .reset (reset_s),
    .bus   (bus1)
  );

  typedef struct {
    int due;
    int d0;
    int o0;
    int d1;
    int o1;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   m0 [DEPTH];
  int   m1 [DEPTH];
  int   sweep_left = DEPTH;
  int   edge_n = 0;
  exp_t q [$];
  int   ev = 0, hd0 = 0, ho0 = 0, hd1 = 0, ho1 = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Table semantics straight from the op definitions, on plain integers
  function automatic void alu(input int old, input int op, input int data, input bit sat,
                              output int nv, output int ovf);
    int s;
    nv  = old;
    ovf = 0;
    if (op == 1 || op == 2) begin
      s   = old + ((op == 1) ? 1 : data);
      ovf = (s > MAXV) ? 1 : 0;
      if (ovf == 1) nv = sat ? MAXV : (s % (MAXV + 1));
      else          nv = s;
    end else if (op == 3) begin
      nv = 0;
    end
  endfunction

  task automatic zero_tables();
    for (int i = 0; i < DEPTH; i++) begin
      m0[i] = 0;
      m1[i] = 0;
    end
  endtask

  // One clock: update the model with the values present at the edge, then compare
  task automatic step();
    exp_t e;
    int   a, n0, o0, n1, o1;
    @(posedge clk);
    edge_n++;
    if (!reset_s) begin
      sweep_left = DEPTH;
      q.delete();
      ev = 0; hd0 = 0; ho0 = 0; hd1 = 0; ho1 = 0;
      zero_tables();
    end else begin
      ev = 0;
      if (q.size() > 0 && q[0].due == edge_n) begin
        e   = q.pop_front();
        ev  = 1;
        hd0 = e.d0; ho0 = e.o0; hd1 = e.d1; ho1 = e.o1;
      end
      if (sweep_left > 0) begin
        sweep_left--;
      end else if (clr_all_s) begin
        sweep_left = DEPTH;
        zero_tables();
      end else if (in_valid_s) begin
        a = int'(in_addr_s);
        alu(m0[a], int'(in_op_s), int'(in_data_s), 1'b0, n0, o0);
        alu(m1[a], int'(in_op_s), int'(in_data_s), 1'b1, n1, o1);
        e.due = edge_n + 1;
        e.d0 = m0[a]; e.o0 = o0; e.d1 = m1[a]; e.o1 = o1;
        m0[a] = n0;
        m1[a] = n1;
        q.push_back(e);
      end
    end
    #1;
    check("wrap_ready", int'(bus0.io_in_ready), int'(sweep_left == 0));
    check("wrap_busy",  int'(bus0.io_busy),     int'(sweep_left != 0));
    check("wrap_valid", int'(bus0.io_out_valid), ev);
    check("wrap_data",  int'(bus0.io_out_data),  hd0);
    check("wrap_ovf",   int'(bus0.io_out_ovf),   ho0);
    check("sat_ready",  int'(bus1.io_in_ready), int'(sweep_left == 0));
    check("sat_busy",   int'(bus1.io_busy),     int'(sweep_left != 0));
    check("sat_valid",  int'(bus1.io_out_valid), ev);
    check("sat_data",   int'(bus1.io_out_data),  hd1);
    check("sat_ovf",    int'(bus1.io_out_ovf),   ho1);
  endtask

  task automatic drv(input logic v, input logic [1:0] op, input int a, input int d, input logic c);
    in_valid_s = v;
    in_op_s    = op;
    in_addr_s  = 3'(a);
    in_data_s  = 4'(d);
    clr_all_s  = c;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 2'b00, 0, 0, 1'b0);
  endtask

  initial begin
    int n;
    reset_s = 1'b0;
    zero_tables();
    idle(3);
    check("reset_ready", int'(bus0.io_in_ready), 0);
    check("reset_data",  int'(bus0.io_out_data), 0);

    // Cycle 0 is the first cycle with reset high
    reset_s = 1'b1;
    n = 0;
    while (!bus0.io_in_ready && n < 20) begin
      idle(1);
      n++;
    end
    check("first_ready_cycle", n, DEPTH);

    for (int a = 0; a < DEPTH; a++) drv(1'b1, 2'b00, a, 0, 1'b0);
    idle(2);

    for (int i = 0; i < 4; i++) drv(1'b1, 2'b01, 3, 0, 1'b0);
    drv(1'b1, 2'b00, 3, 0, 1'b0);
    idle(2);

    drv(1'b1, 2'b10, 1, 15, 1'b0);
    drv(1'b1, 2'b01, 1, 0, 1'b0);
    drv(1'b1, 2'b00, 1, 0, 1'b0);
    idle(2);

    drv(1'b1, 2'b10, 2, 5, 1'b0);
    drv(1'b1, 2'b11, 2, 0, 1'b0);
    drv(1'b1, 2'b01, 2, 0, 1'b0);
    drv(1'b1, 2'b00, 2, 0, 1'b0);
    idle(2);

    // INC then clear-all with a competing request that must be dropped
    drv(1'b1, 2'b01, 0, 0, 1'b0);
    drv(1'b1, 2'b01, 4, 0, 1'b1);
    n = 0;
    while (bus0.io_busy && n < 20) begin
      idle(1);
      n++;
    end
    check("clr_busy_len", n, DEPTH);
    drv(1'b1, 2'b00, 0, 0, 1'b0);
    drv(1'b1, 2'b00, 4, 0, 1'b0);
    idle(2);

    // Reset while an INC sits in S1
    drv(1'b1, 2'b01, 5, 0, 1'b0);
    reset_s = 1'b0;
    idle(1);
    reset_s = 1'b1;
    idle(DEPTH + 1);
    drv(1'b1, 2'b00, 5, 0, 1'b0);
    idle(2);

    for (int i = 0; i < 800; i++) begin
      reset_s = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
      drv(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
          2'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)),
          int'($urandom_range(0, 15)),
          ($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0);
    end
    reset_s = 1'b1;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rmw_counter_table.md
# rmw_counter_table

Parametrised fetch-and-operate counter memory with registered read/modify/write: one operation per cycle (read, increment, add, clear) on a DEPTH x WIDTH table. Returns the pre-operation value two cycles after acceptance. It is the pipelined, multi-op, hazard-safe successor to the single-cycle increment-in-place memory, used for statistics and histogram counters. It also adds hardware table initialisation after reset and on request.

## Interface
Parameters:
- DEPTH, 8: number of entries, power of two, >= 2
- WIDTH, 32: entry width, >= 2
- ADDR_W, clog2(DEPTH): address width, derived
- SATURATE, 0: 0 = arithmetic wraps mod 2^WIDTH; 1 = clamps at all-ones

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-low
- io_in_valid  in  1  operation request
- io_in_ready  out  1  request accepted when valid && ready
- io_in_op  in  2  00 READ, 01 INC, 10 ADD, 11 CLR
- io_in_addr  in  ADDR_W  entry index
- io_in_data  in  WIDTH  addend for ADD, ignored otherwise
- io_clr_all  in  1  pulse: zero whole table; sampled only when io_in_ready
- io_out_valid  out  1  one-cycle pulse per accepted op, no backpressure
- io_out_data  out  WIDTH  entry value before the operation
- io_out_ovf  out  1  op wrapped (SATURATE=0) or clamped (SATURATE=1)
- io_busy  out  1  initialisation sweep in progress

## Operation
- States: SWEEP, RUN.
- While reset is low: state forced to SWEEP, sweep pointer 0, S1 invalid. All outputs read 0 except io_busy=1 and io_in_ready=0.
- SWEEP:
  - Write 0 to mem[ptr] each cycle, then ptr++.
  - After writing DEPTH-1, go to RUN on the next edge.
  - The sweep takes exactly DEPTH cycles. No requests are accepted.
- RUN: io_in_ready=1, io_busy=0.
  - io_clr_all=1 enters SWEEP with ptr=0 on the next edge.
  - io_clr_all has priority over a simultaneous io_in_valid; that request is not accepted.
- Pipeline:
  - Accept cycle t: synchronous read of mem[io_in_addr] is captured at the end of t, together with op, addr and data, into S1.
  - S1 (cycle t+1) computes new value:
    - READ: old, no write.
    - INC: old+1.
    - ADD: old+data.
    - CLR: 0.
  - S1 writes the new value at the end of t+1 and registers old into io_out_data at the same edge.
- Hazard: if the op accepted in cycle t+1 targets the same address S1 is writing, the captured operand is S1's new value, not the RAM read. Back-to-back ops on one address must behave sequentially.
- Overflow, SATURATE=0: the result is (old+inc) mod 2^WIDTH, and ovf=1 on carry out.
- Overflow, SATURATE=1: the result is all-ones when the sum exceeds it, and ovf=1.
- READ and CLR always give ovf=0.
- Sweep/S1 collision: on the first SWEEP cycle a pending S1 op still completes and reports its output. The sweep write has port priority, so the entry ends zero.

## Timing
- Latency: accept in cycle t gives io_out_valid in cycle t+2. Throughput is 1 op/cycle in RUN.
- io_out_data and io_out_ovf hold their last values when io_out_valid=0. They are 0 after reset.
- Reset asserted mid-operation: the in-flight S1 op is discarded, no output pulse is produced, and the table is re-zeroed by the sweep.
- First acceptance is possible in cycle DEPTH after reset is released. Reset release is cycle 0.

## Structure
- Shared package rmw_counter_pkg:
  - op encodings OP_READ, OP_INC, OP_ADD, OP_CLR
  - state enum SWEEP/RUN
  - clog2 helper
- Sub-module rmw_table_ram: DEPTH x WIDTH, one synchronous read port, one write port, no reset on the array.
- Top level holds the FSM, sweep pointer, S1 registers, forwarding compare, ALU with saturate/wrap, and output registers.

## Test plan
- Reset, then READ of all addresses at DEPTH=8: ready rises in cycle 8, and every io_out_data=0 with ovf=0.
- INC addr 3 on four consecutive cycles, then READ 3: outputs are 0,1,2,3, then 4. This exercises the forwarding path every cycle.
- WIDTH=4, SATURATE=0: ADD 15 to addr 1, then INC addr 1, then READ addr 1. Outputs are 0, then 15 with ovf=1, then 0.
- Same sequence with SATURATE=1: final READ returns 15, and the INC reports ovf=1.
- Interleave ADD 5 at addr 2, CLR addr 2, INC addr 2, READ addr 2: outputs are 0, 5, 0, then 1.
- Two scenarios around initialisation:
  - INC addr 0 accepted, then io_clr_all in the next cycle: the INC output still appears with value 0, busy=1 for 8 cycles, and READ 0 afterwards returns 0.
  - Reset pulsed during S1: no io_out_valid pulse.
